instr_sequencer: RTL and testbench

Multi-cycle sequencer that drives the processor's fetch/decode/execute/writeback loop around the single-cycle ALU and register file. Fetches 32-bit instructions over a req/ack handshake and decodes the 6-bit opcode (ADD/SUB/AND/OR). Issues ALU enable and register addresses, then commits a write-back pulse. Maintains PC and retired-instruction count, and honours start/halt requests from the system.

---
 rtl/instr_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/WB controller around a single-cycle ALU and register file.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes park in a TRAP state instead of retiring as NOPs.
module instr_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned RET_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             alu_enable,
  output logic [1:0]       alu_op,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       wb_addr,
  output logic             we,
  output logic             busy,
  output logic [PC_W-1:0]  pc,
  output logic [RET_W-1:0] retired,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic             legal_q, legal_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       rs_q, rs_d;
  logic [4:0]       rt_q, rt_d;
  logic [4:0]       wbad_q, wbad_d;
  logic             req_q, req_d;
  logic             aen_q, aen_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             ir_legal;
  logic             unused_ir_bits;

  // Legal opcodes are 0..3, i.e. the top four opcode bits are clear.
  assign ir_legal       = (ir_q[31:28] == 4'b0000);
  assign unused_ir_bits = ^ir_q[10:0];

`ifdef ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    legal_d = legal_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wbad_d  = wbad_q;
`ifdef ILLEGAL_TRAP_EN
    trap_d  = trap_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        legal_d = ir_legal;
        if (ir_legal) begin
          op_d    = ir_q[27:26];
          rs_d    = ir_q[25:21];
          rt_d    = ir_q[20:16];
          wbad_d  = ir_q[15:11];
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          trap_d  = 1'b1;
          state_d = S_TRAP;
`else
          state_d = S_WB;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        if (legal_q && (ret_q != '1)) ret_d = ret_q + RET_W'(1);
        pc_d    = pc_q + PC_W'(1);
        state_d = halt_req ? S_IDLE : S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        if (start) begin
          trap_d  = 1'b0;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they appear registered in their own state.
    req_d  = (state_d == S_FETCH);
    aen_d  = (state_d == S_EXEC);
    we_d   = (state_d == S_WB) && legal_d && (wbad_d != '0);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
      legal_q <= 1'b0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      wbad_q  <= '0;
      req_q   <= 1'b0;
      aen_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      legal_q <= legal_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wbad_q  <= wbad_d;
      req_q   <= req_d;
      aen_q   <= aen_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
`ifdef ILLEGAL_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign alu_enable = aen_q;
  assign alu_op     = op_q;
  assign rs_addr    = rs_q;
  assign rt_addr    = rt_q;
  assign wb_addr    = wbad_q;
  assign we         = we_q;
  assign busy       = busy_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: an instruction-level model predicts each phase of every instruction.
module tb_instr_sequencer;
  localparam int unsigned PC_W  = 2;
  localparam int unsigned RET_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             halt_req = 1'b0;
  logic             imem_ack = 1'b0;
  logic [31:0]      imem_rdata = '0;
  logic             imem_req, alu_enable, we, busy, trap;
  logic [PC_W-1:0]  imem_addr, pc;
  logic [1:0]       alu_op;
  logic [4:0]       rs_addr, rt_addr, wb_addr;
  logic [RET_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Architectural model: instruction-level state only.
  int unsigned m_pc = 0;
  int unsigned m_ret = 0;
  logic [1:0]  m_op = '0;
  logic [4:0]  m_rs = '0, m_rt = '0, m_wb = '0;
  logic [31:0] prog[$];
  int          dlys[$];

  instr_sequencer #(.PC_W(PC_W), .RET_W(RET_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_enable(alu_enable), .alu_op(alu_op), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wb_addr(wb_addr), .we(we), .busy(busy), .pc(pc), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {op, rs, rt, rd, 11'h0};
  endfunction

  function automatic logic [31:0] rand_instr(input bit force_legal);
    logic [5:0] op;
    if (force_legal || $urandom_range(0, 9) < 7) op = 6'($urandom_range(0, 3));
    else op = 6'($urandom_range(4, 63));
    return mk(op, 5'($urandom), 5'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
  endfunction

  // Runs prog[] from IDLE; the last instruction carries halt_req from its first FETCH cycle.
  task automatic run_prog(input bit noise);
    int n, d, t0;
    logic [31:0] ins;
    bit legal, exp_we;
    n = prog.size();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      ins = prog[k];
      d = dlys[k];
      legal = (ins[31:26] < 6'd4);
      exp_we = legal && (ins[15:11] != 5'd0);
      t0 = cyc;
      if (k == n - 1) halt_req = 1'b1;
      for (int w = 0; w <= d; w++) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== PC_W'(m_pc) || busy !== 1'b1 || alu_enable !== 1'b0 || we !== 1'b0) begin
          errors++;
          $display("FAIL fetch k=%0d w=%0d req=%b addr=%0d aen=%b we=%b busy=%b, need req=1 addr=%0d aen=0 we=0 busy=1",
                   k, w, imem_req, imem_addr, alu_enable, we, busy, m_pc);
        end
        checks++;
        if ({alu_op, rs_addr, rt_addr, wb_addr} !== {m_op, m_rs, m_rt, m_wb}) begin
          errors++;
          $display("FAIL hold k=%0d op/rs/rt/wb=%0d/%0d/%0d/%0d, need %0d/%0d/%0d/%0d",
                   k, alu_op, rs_addr, rt_addr, wb_addr, m_op, m_rs, m_rt, m_wb);
        end
        imem_ack = (w == d);
        imem_rdata = (w == d) ? ins : $urandom;
        step();
      end
      imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
      checks++;
      if (imem_req !== 1'b0 || alu_enable !== 1'b0 || we !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL decode k=%0d req=%b aen=%b we=%b busy=%b, need 0 0 0 1", k, imem_req, alu_enable, we, busy);
      end
      step();
      if (legal) begin
        m_op = ins[27:26]; m_rs = ins[25:21]; m_rt = ins[20:16]; m_wb = ins[15:11];
        checks++;
        if (alu_enable !== 1'b1 || we !== 1'b0 || imem_req !== 1'b0 ||
            {alu_op, rs_addr, rt_addr, wb_addr} !== {m_op, m_rs, m_rt, m_wb}) begin
          errors++;
          $display("FAIL exec k=%0d aen=%b we=%b req=%b op/rs/rt/wb=%0d/%0d/%0d/%0d, need aen=1 we=0 req=0 %0d/%0d/%0d/%0d",
                   k, alu_enable, we, imem_req, alu_op, rs_addr, rt_addr, wb_addr, m_op, m_rs, m_rt, m_wb);
        end
        step();
      end
`ifdef ILLEGAL_TRAP_EN
      if (!legal) begin
        for (int h = 0; h < 2; h++) begin
          checks++;
          if (trap !== 1'b1 || busy !== 1'b1 || pc !== PC_W'(m_pc) || we !== 1'b0 || alu_enable !== 1'b0 ||
              retired !== RET_W'(m_ret)) begin
            errors++;
            $display("FAIL trap k=%0d trap=%b busy=%b pc=%0d we=%b aen=%b ret=%0d, need 1 1 %0d 0 0 %0d",
                     k, trap, busy, pc, we, alu_enable, retired, m_pc, m_ret);
          end
          step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc = (m_pc + 1) % (1 << PC_W);
        checks++;
        if (trap !== 1'b0) begin
          errors++;
          $display("FAIL trap_clear k=%0d trap=%b, need 0", k, trap);
        end
        continue;
      end
`endif
      checks++;
      if (we !== exp_we || alu_enable !== 1'b0 || busy !== 1'b1 || (exp_we && wb_addr !== ins[15:11]) ||
          pc !== PC_W'(m_pc) || retired !== RET_W'(m_ret)) begin
        errors++;
        $display("FAIL wb k=%0d we=%b aen=%b busy=%b wb=%0d pc=%0d ret=%0d, need we=%b aen=0 busy=1 wb=%0d pc=%0d ret=%0d",
                 k, we, alu_enable, busy, wb_addr, pc, retired, exp_we, ins[15:11], m_pc, m_ret);
      end
      checks++;
      if (cyc - t0 !== d + (legal ? 3 : 2)) begin
        errors++;
        $display("FAIL latency k=%0d fetch_to_wb=%0d, need %0d", k, cyc - t0, d + (legal ? 3 : 2));
      end
      step();
      m_pc = (m_pc + 1) % (1 << PC_W);
      if (legal && m_ret < (1 << RET_W) - 1) m_ret++;
    end
    halt_req = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || we !== 1'b0 || pc !== PC_W'(m_pc) || retired !== RET_W'(m_ret)) begin
      errors++;
      $display("FAIL halted busy=%b req=%b we=%b pc=%0d ret=%0d, need 0 0 0 %0d %0d",
               busy, imem_req, we, pc, retired, m_pc, m_ret);
    end
    step();
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_stay busy=%b req=%b, need 0 0", busy, imem_req);
    end
    prog.delete();
    dlys.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({imem_req, alu_enable, we, busy, trap, alu_op, rs_addr, rt_addr, wb_addr, pc, imem_addr, retired} !== '0) begin
      errors++;
      $display("FAIL reset req=%b aen=%b we=%b busy=%b trap=%b op=%0d rs=%0d rt=%0d wb=%0d pc=%0d ret=%0d, need all 0",
               imem_req, alu_enable, we, busy, trap, alu_op, rs_addr, rt_addr, wb_addr, pc, retired);
    end
    rst_n = 1'b1;
    step();
    m_pc = 0; m_ret = 0; m_op = '0; m_rs = '0; m_rt = '0; m_wb = '0;
  endtask

  task automatic test_basic_add();
    prog.push_back(32'h0022_1800); dlys.push_back(0);
    run_prog(1'b0);
  endtask

  task automatic test_fetch_wait();
    prog.push_back(mk(6'd0, 5'd7, 5'd9, 5'd12)); dlys.push_back(3);
    run_prog(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int op = 1; op <= 3; op++) begin
      prog.push_back(mk(6'(op), 5'(op + 4), 5'(op + 8), 5'(op + 16)));
      dlys.push_back(0);
    end
    run_prog(1'b0);
  endtask

  task automatic test_rd_zero_and_illegal();
    prog.push_back(mk(6'd0, 5'd4, 5'd5, 5'd0));   dlys.push_back(0);
    prog.push_back(mk(6'h3F, 5'd6, 5'd7, 5'd8));  dlys.push_back(1);
    prog.push_back(mk(6'd2, 5'd10, 5'd11, 5'd9)); dlys.push_back(0);
    run_prog(1'b1);
  endtask

  task automatic test_halt_wrap();
    for (int i = 0; i < 5; i++) begin
      prog.push_back(rand_instr(1'b1));
      dlys.push_back(0);
    end
    run_prog(1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        prog.push_back(rand_instr(i == 11));
        dlys.push_back($urandom_range(0, 3));
      end
      run_prog(1'b1);
    end
  endtask

  task automatic test_reset_mid_exec();
    start = 1'b1;
    step();
    start = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = mk(6'd1, 5'd3, 5'd4, 5'd5);
    step();
    imem_ack = 1'b0;
    step();
    checks++;
    if (alu_enable !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_exec aen=%b, need 1", alu_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (alu_enable !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || pc !== '0 || retired !== '0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset aen=%b we=%b busy=%b pc=%0d ret=%0d req=%b, need all 0",
               alu_enable, we, busy, pc, retired, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) rst_n = 1'b1;
      checks++;
      if (we !== 1'b0 || busy !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL post_reset i=%0d we=%b busy=%b req=%b, need 0 0 0", i, we, busy, imem_req);
      end
    end
    m_pc = 0; m_ret = 0; m_op = '0; m_rs = '0; m_rt = '0; m_wb = '0;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_fetch_wait();
    test_back_to_back();
    test_rd_zero_and_illegal();
    test_halt_wrap();
    test_random();
    test_reset_mid_exec();
    test_basic_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
